// File: rtl/rx_frame_filter_if.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | rx_frame_filter_if                                                 |
// | Buffer/parser handshake, window config and status of the filter.   |
// | Revision: 1.0                                                      |
// +--------------------------------------------------------------------+
interface rx_frame_filter_if #(
   parameter int ID_W  = 8,
   parameter int CNT_W = 16
);
   logic              init_done;
   logic              rx_done;
   logic              rx_crc_rslt;
   logic              got_frame;
   logic [ID_W-1:0]   frame_id;
   logic [7:0]        frame_type;
   logic              sn_error;
   logic              cfg_we;
   logic [2:0]        cfg_idx;
   logic [ID_W-1:0]   cfg_min;
   logic [ID_W-1:0]   cfg_max;
   logic              cfg_en;
   logic              load_rd_en;
   logic              ack_rd_en;
   logic              pass_rd_en;
   logic              drop_rd_en;
   logic              busy;
   logic [CNT_W-1:0]  acc_cnt;
   logic [CNT_W-1:0]  drop_cnt;
   logic [CNT_W-1:0]  crc_cnt;

   modport master (
      output init_done, rx_done, rx_crc_rslt, got_frame, frame_id, frame_type,
             sn_error, cfg_we, cfg_idx, cfg_min, cfg_max, cfg_en,
      input  load_rd_en, ack_rd_en, pass_rd_en, drop_rd_en, busy,
             acc_cnt, drop_cnt, crc_cnt
   );

   modport slave (
      input  init_done, rx_done, rx_crc_rslt, got_frame, frame_id, frame_type,
             sn_error, cfg_we, cfg_idx, cfg_min, cfg_max, cfg_en,
      output load_rd_en, ack_rd_en, pass_rd_en, drop_rd_en, busy,
             acc_cnt, drop_cnt, crc_cnt
   );
endinterface
`default_nettype wire

// File: rtl/rx_frame_filter.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | rx_frame_filter                                                    |
// | Classifies received frames by ID window and type; releases/drops.  |
// | Revision: 1.0                                                      |
// +--------------------------------------------------------------------+
module rx_frame_filter #(
   parameter int         NUM_WIN   = 4,
   parameter int         ID_W      = 8,
   parameter logic [7:0] ACK_TYPE  = 8'h32,
   parameter logic [7:0] PASS_TYPE = 8'h51,
   parameter int         SN_WAIT   = 4,
   parameter int         HDR_TO    = 64,
   parameter int         CNT_W     = 16
) (
   input  wire               sys_clk,
   input  wire               glbl_rst_n,
   rx_frame_filter_if.slave  bus
);
   localparam int c_HDR_W = $clog2(HDR_TO + 1);
   localparam int c_SN_W  = $clog2(SN_WAIT + 1);
   localparam logic [c_HDR_W-1:0] c_HDR_LAST = c_HDR_W'(HDR_TO - 1);
   localparam logic [c_SN_W-1:0]  c_SN_LAST  = c_SN_W'(SN_WAIT - 1);

   typedef enum logic [2:0] {
      S_INIT     = 3'd0,
      S_IDLE     = 3'd1,
      S_WAIT_HDR = 3'd2,
      S_SN_ACK   = 3'd3,
      S_SN_PASS  = 3'd4,
      S_DROP     = 3'd5
   } state_t;

   // Asynchronous assertion, release retimed through two flops.
   logic [1:0] r_rst_sync;
   logic       w_rst_n;

   always_ff @(posedge sys_clk or negedge glbl_rst_n) begin
      if (!glbl_rst_n) r_rst_sync <= 2'b00;
      else             r_rst_sync <= {r_rst_sync[0], 1'b1};
   end
   assign w_rst_n = r_rst_sync[1];

   logic [NUM_WIN-1:0] w_hit_vec;
   logic               w_hit;

   for (genvar w = 0; w < NUM_WIN; w++) begin : g_win
      logic            r_en;
      logic [ID_W-1:0] r_min;
      logic [ID_W-1:0] r_max;

      always_ff @(posedge sys_clk or negedge w_rst_n) begin
         if (!w_rst_n) begin
            r_en  <= 1'b0;
            r_min <= '0;
            r_max <= '0;
         end else if (bus.cfg_we && (bus.cfg_idx == 3'(w))) begin
            r_en  <= bus.cfg_en;
            r_min <= bus.cfg_min;
            r_max <= bus.cfg_max;
         end
      end

      // An inverted window (min > max) can never satisfy both bounds.
      assign w_hit_vec[w] = r_en && (bus.frame_id >= r_min) && (bus.frame_id <= r_max);
   end

   assign w_hit = |w_hit_vec;

   state_t             r_state;
   logic [c_HDR_W-1:0] r_hdr_cnt;
   logic [c_SN_W-1:0]  r_sn_cnt;
   logic               r_load;
   logic               r_ack;
   logic               r_pass;
   logic               r_drop;
   logic [CNT_W-1:0]   r_acc_cnt;
   logic [CNT_W-1:0]   r_drop_cnt;
   logic [CNT_W-1:0]   r_crc_cnt;

   always_ff @(posedge sys_clk or negedge w_rst_n) begin
      if (!w_rst_n) begin
         r_state    <= S_INIT;
         r_hdr_cnt  <= '0;
         r_sn_cnt   <= '0;
         r_load     <= 1'b0;
         r_ack      <= 1'b0;
         r_pass     <= 1'b0;
         r_drop     <= 1'b0;
         r_acc_cnt  <= '0;
         r_drop_cnt <= '0;
         r_crc_cnt  <= '0;
      end else begin
         r_load <= 1'b0;
         r_ack  <= 1'b0;
         r_pass <= 1'b0;
         r_drop <= 1'b0;
         if (!bus.init_done) begin
            r_state <= S_INIT;
         end else begin
            case (r_state)
               S_INIT: r_state <= S_IDLE;
               S_IDLE: begin
                  if (bus.rx_done) begin
                     if (bus.rx_crc_rslt) begin
                        r_state   <= S_WAIT_HDR;
                        r_load    <= 1'b1;
                        r_hdr_cnt <= '0;
                     end else if (r_crc_cnt != '1) begin
                        r_crc_cnt <= r_crc_cnt + CNT_W'(1);
                     end
                  end
               end
               S_WAIT_HDR: begin
                  if (bus.got_frame) begin
                     r_sn_cnt <= '0;
                     if (w_hit && (bus.frame_type == ACK_TYPE)) begin
                        r_state <= S_SN_ACK;
                     end else if (w_hit && (bus.frame_type == PASS_TYPE)) begin
                        r_state <= S_SN_PASS;
                     end else begin
                        r_state <= S_DROP;
                        r_drop  <= 1'b1;
                     end
                  end else if (r_hdr_cnt == c_HDR_LAST) begin
                     r_state <= S_DROP;
                     r_drop  <= 1'b1;
                  end else begin
                     r_hdr_cnt <= r_hdr_cnt + c_HDR_W'(1);
                  end
               end
               S_SN_ACK, S_SN_PASS: begin
                  if (bus.sn_error) begin
                     r_state <= S_DROP;
                     r_drop  <= 1'b1;
                  end else if (r_sn_cnt == c_SN_LAST) begin
                     r_state <= S_IDLE;
                     r_ack   <= (r_state == S_SN_ACK);
                     r_pass  <= (r_state == S_SN_PASS);
                     if (r_acc_cnt != '1) r_acc_cnt <= r_acc_cnt + CNT_W'(1);
                  end else begin
                     r_sn_cnt <= r_sn_cnt + c_SN_W'(1);
                  end
               end
               S_DROP: begin
                  r_state <= S_IDLE;
                  if (r_drop_cnt != '1) r_drop_cnt <= r_drop_cnt + CNT_W'(1);
               end
               default: r_state <= S_INIT;
            endcase
         end
      end
   end

   assign bus.load_rd_en = r_load;
   assign bus.ack_rd_en  = r_ack;
   assign bus.pass_rd_en = r_pass;
   assign bus.drop_rd_en = r_drop;
   assign bus.busy       = (r_state != S_INIT) && (r_state != S_IDLE);
   assign bus.acc_cnt    = r_acc_cnt;
   assign bus.drop_cnt   = r_drop_cnt;
   assign bus.crc_cnt    = r_crc_cnt;
endmodule
`default_nettype wire
